// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC/fetch stage: CTRL command codes, fetch FSM states
// and the decode of the CTRL command into a PC action.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    CTRL_DEFAULT = 2'b00,
    CTRL_BLOCK   = 2'b01,
    CTRL_BUBBLE  = 2'b10,
    CTRL_BRANCH  = 2'b11
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10,
    FETCH_OUT  = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    CMD_RUN      = 2'b00,
    CMD_HOLD     = 2'b01,
    CMD_REDIRECT = 2'b10
  } pc_cmd_e;

  // Branch wins over everything; a bubble request on the PC side just stalls it.
  function automatic pc_cmd_e decode_ctrl(input logic [1:0] ctrl);
    pc_cmd_e cmd;
    case (ctrl)
      CTRL_BRANCH:              cmd = CMD_REDIRECT;
      CTRL_BLOCK, CTRL_BUBBLE:  cmd = CMD_HOLD;
      CTRL_DEFAULT:             cmd = CMD_RUN;
      default:                  cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding-request instruction fetch stage feeding IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds fetched-instruction and stall-cycle counters.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h8000_0000),
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctrl_signal_pc_i,
  input  logic [ADDR_W-1:0] ctrl_to_pc_new_i,
  output logic              icache_req_o,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic              icache_ready_i,
  input  logic              icache_data_valid_i,
  input  logic [DATA_W-1:0] icache_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  pc_cmd_e           cmd;
  logic              accept;
  logic              latch_inst;
  logic              release_inst;

  assign cmd           = decode_ctrl(ctrl_signal_pc_i);
  assign icache_req_o  = !rst && (state == FETCH_REQ) && (cmd != CMD_HOLD);
  assign icache_addr_o = pc;
  assign accept        = icache_req_o && icache_ready_i;

  // Next-state, next-PC and output-register control keyed on the fetch state.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    latch_inst   = 1'b0;
    release_inst = 1'b0;
    case (state)
      FETCH_REQ: begin
        if (cmd == CMD_REDIRECT) begin
          // The request just issued used the old PC, so its response must be dropped.
          pc_next    = ctrl_to_pc_new_i;
          state_next = accept ? FETCH_DROP : FETCH_REQ;
        end else if (cmd == CMD_RUN) begin
          state_next = accept ? FETCH_WAIT : FETCH_REQ;
        end else begin
          state_next = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (cmd == CMD_REDIRECT) begin
          pc_next    = ctrl_to_pc_new_i;
          state_next = icache_data_valid_i ? FETCH_REQ : FETCH_DROP;
        end else if (icache_data_valid_i) begin
          // Latch even under Block so the response is never lost.
          latch_inst = 1'b1;
          state_next = FETCH_OUT;
        end else begin
          state_next = FETCH_WAIT;
        end
      end
      FETCH_DROP: begin
        if (cmd == CMD_REDIRECT) begin
          pc_next = ctrl_to_pc_new_i;
        end else begin
          pc_next = pc;
        end
        state_next = icache_data_valid_i ? FETCH_REQ : FETCH_DROP;
      end
      FETCH_OUT: begin
        if (cmd == CMD_REDIRECT) begin
          pc_next      = ctrl_to_pc_new_i;
          release_inst = 1'b1;
          state_next   = FETCH_REQ;
        end else if (cmd == CMD_RUN) begin
          pc_next      = pc + PC_STEP;
          release_inst = 1'b1;
          state_next   = FETCH_REQ;
        end else begin
          state_next = FETCH_OUT;
        end
      end
      default: begin
        state_next = FETCH_REQ;
      end
    endcase
  end

  // State, PC and the registered IF/ID-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_REQ;
      pc         <= RESET_PC;
      if_valid_o <= 1'b0;
      if_pc_o    <= RESET_PC;
      if_inst_o  <= NOP_INST;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (latch_inst) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= pc;
        if_inst_o  <= icache_data_i;
      end else if (release_inst) begin
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP_INST;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Consumed-instruction and waiting-on-I-cache cycle counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_o <= 32'd0;
      perf_stall_cnt_o <= 32'd0;
    end else begin
      if ((state == FETCH_OUT) && (cmd == CMD_RUN)) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if ((state == FETCH_WAIT) || (state == FETCH_DROP)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a flag-based reference model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [1:0]  ctrl;
  logic [31:0] target;
  logic        ready;
  logic        dvalid;
  logic [31:0] data;
  logic        req,   req_w;
  logic [31:0] addr,  addr_w;
  logic        vld,   vld_w;
  logic [31:0] ipc,   ipc_w;
  logic [31:0] inst,  inst_w;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_fetch_w, perf_stall_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .ctrl_signal_pc_i(ctrl), .ctrl_to_pc_new_i(target),
    .icache_req_o(req), .icache_addr_o(addr), .icache_ready_i(ready),
    .icache_data_valid_i(dvalid), .icache_data_i(data),
    .if_valid_o(vld), .if_pc_o(ipc), .if_inst_o(inst)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_stall_cnt_o(perf_stall)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .ctrl_signal_pc_i(ctrl), .ctrl_to_pc_new_i(target),
    .icache_req_o(req_w), .icache_addr_o(addr_w), .icache_ready_i(ready),
    .icache_data_valid_i(dvalid), .icache_data_i(data),
    .if_valid_o(vld_w), .if_pc_o(ipc_w), .if_inst_o(inst_w)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch_w), .perf_stall_cnt_o(perf_stall_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic [1:0] c, input logic r, input logic v,
                       input logic [31:0] d, input logic [31:0] t);
    @(negedge clk);
    ctrl = c; ready = r; dvalid = v; data = d; target = t;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ctrl = CTRL_DEFAULT; ready = 1'b0; dvalid = 1'b0; data = 32'd0; target = 32'd0;
    #1;
    check1("reset-cycle req", req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("reset valid", vld, 1'b0);
    check32("reset if_pc", ipc, 32'h8000_0000);
    check32("reset if_inst", inst, NOP);
    check32("reset addr", addr, 32'h8000_0000);
  endtask

`ifdef FETCH_PERF_CNT_EN
  // One instruction: accept, two cycles of latency, consume.
  task automatic fetch_one(input logic [31:0] d);
    drive(CTRL_DEFAULT, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(CTRL_DEFAULT, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(CTRL_DEFAULT, 1'b1, 1'b1, d, 32'd0);
    drive(CTRL_DEFAULT, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) + 32'h0001_0003;
  endfunction

  typedef struct {
    logic [1:0]  c;
    logic        r;
    logic        v;
    logic [31:0] d;
    logic [31:0] t;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[27];

  // Reference model state: an outstanding request, whether its response is stale,
  // and whether an instruction is currently held for IF/ID.
  logic [31:0] m_pc, m_ipc, m_inst;
  bit          m_busy, m_stale, m_hold;
  int unsigned m_fetch, m_stall;

  initial begin
    rst = 1'b1; ctrl = CTRL_DEFAULT; ready = 1'b0; dvalid = 1'b0; data = 32'd0; target = 32'd0;

    vecs[0]  = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0000, 1'b0, 32'h0,         NOP};
    vecs[1]  = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0000, 1'b0, 32'h0,         NOP};
    vecs[2]  = '{CTRL_DEFAULT, 1'b1, 1'b1, 32'h0050_0093, 32'h0,         1'b0, 32'h8000_0000, 1'b0, 32'h0,         NOP};
    vecs[3]  = '{CTRL_BLOCK,   1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0050_0093};
    vecs[4]  = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0050_0093};
    vecs[5]  = '{CTRL_DEFAULT, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0004, 1'b0, 32'h0,         NOP};
    vecs[6]  = '{CTRL_BRANCH,  1'b1, 1'b0, 32'h0,         32'h8000_0100, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         NOP};
    vecs[7]  = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0100, 1'b0, 32'h0,         NOP};
    vecs[8]  = '{CTRL_DEFAULT, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h8000_0100, 1'b0, 32'h0,         NOP};
    vecs[9]  = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0100, 1'b0, 32'h0,         NOP};
    vecs[10] = '{CTRL_BRANCH,  1'b1, 1'b0, 32'h0,         32'h8000_0200, 1'b0, 32'h8000_0100, 1'b0, 32'h0,         NOP};
    vecs[11] = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0200, 1'b0, 32'h0,         NOP};
    vecs[12] = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0200, 1'b0, 32'h0,         NOP};
    vecs[13] = '{CTRL_DEFAULT, 1'b1, 1'b1, 32'h1111_1111, 32'h0,         1'b0, 32'h8000_0200, 1'b0, 32'h0,         NOP};
    vecs[14] = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0200, 1'b0, 32'h0,         NOP};
    vecs[15] = '{CTRL_BRANCH,  1'b1, 1'b1, 32'h2222_2222, 32'h8000_0300, 1'b0, 32'h8000_0200, 1'b0, 32'h0,         NOP};
    vecs[16] = '{CTRL_DEFAULT, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0300, 1'b0, 32'h0,         NOP};
    vecs[17] = '{CTRL_BLOCK,   1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0300, 1'b0, 32'h0,         NOP};
    vecs[18] = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0300, 1'b0, 32'h0,         NOP};
    vecs[19] = '{CTRL_DEFAULT, 1'b1, 1'b1, 32'h3333_3333, 32'h0,         1'b0, 32'h8000_0300, 1'b0, 32'h0,         NOP};
    vecs[20] = '{CTRL_BRANCH,  1'b1, 1'b0, 32'h0,         32'h8000_0404, 1'b0, 32'h8000_0300, 1'b1, 32'h8000_0300, 32'h3333_3333};
    vecs[21] = '{CTRL_BUBBLE,  1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h8000_0404, 1'b0, 32'h0,         NOP};
    vecs[22] = '{CTRL_DEFAULT, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0404, 1'b0, 32'h0,         NOP};
    vecs[23] = '{CTRL_BRANCH,  1'b1, 1'b0, 32'h0,         32'h8000_0500, 1'b0, 32'h8000_0404, 1'b0, 32'h0,         NOP};
    vecs[24] = '{CTRL_BRANCH,  1'b1, 1'b0, 32'h0,         32'h8000_0600, 1'b0, 32'h8000_0500, 1'b0, 32'h0,         NOP};
    vecs[25] = '{CTRL_DEFAULT, 1'b1, 1'b1, 32'h4444_4444, 32'h0,         1'b0, 32'h8000_0600, 1'b0, 32'h0,         NOP};
    vecs[26] = '{CTRL_DEFAULT, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0600, 1'b0, 32'h0,         NOP};

    // Directed vectors: basic fetch, redirects in every state, stale-response drops.
    do_reset();
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].c, vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].t);
      check1($sformatf("vec%0d req", i), req, vecs[i].e_req);
      check32($sformatf("vec%0d addr", i), addr, vecs[i].e_addr);
      check1($sformatf("vec%0d valid", i), vld, vecs[i].e_vld);
      check32($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
      if (vecs[i].e_vld) begin
        check32($sformatf("vec%0d if_pc", i), ipc, vecs[i].e_pc);
      end
    end

    // Block during WAIT, held output for 5 cycles, release; wrap instance checks pc+4 wrap.
    do_reset();
    check32("wrap reset addr", addr_w, 32'hFFFF_FFFC);
    drive(CTRL_DEFAULT, 1'b1, 1'b0, 32'd0, 32'd0);
    check1("blk accept req", req, 1'b1);
    drive(CTRL_BLOCK, 1'b1, 1'b0, 32'd0, 32'd0);
    check1("blk wait req", req, 1'b0);
    drive(CTRL_BLOCK, 1'b1, 1'b1, 32'h00A0_0113, 32'd0);
    check1("blk resp valid", vld, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(CTRL_BLOCK, 1'b1, 1'b0, 32'd0, 32'd0);
      check1($sformatf("blk hold%0d valid", i), vld, 1'b1);
      check32($sformatf("blk hold%0d inst", i), inst, 32'h00A0_0113);
      check32($sformatf("blk hold%0d if_pc", i), ipc, 32'h8000_0000);
      check1($sformatf("blk hold%0d req", i), req, 1'b0);
    end
    check32("wrap held if_pc", ipc_w, 32'hFFFF_FFFC);
    check1("wrap held valid", vld_w, 1'b1);
    drive(CTRL_DEFAULT, 1'b1, 1'b0, 32'd0, 32'd0);
    check1("blk consume valid", vld, 1'b1);
    drive(CTRL_DEFAULT, 1'b0, 1'b0, 32'd0, 32'd0);
    check1("blk next req", req, 1'b1);
    check32("blk next addr", addr, 32'h8000_0004);
    check1("blk next valid", vld, 1'b0);
    check32("blk next inst", inst, NOP);
    check32("wrap next addr", addr_w, 32'h0000_0000);
    check1("wrap next req", req_w, 1'b1);
    check32("wrap next inst", inst_w, NOP);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch_one(32'h0000_1000 + 32'(i));
    end
    drive(CTRL_DEFAULT, 1'b0, 1'b0, 32'd0, 32'd0);
    check32("perf fetch 10", perf_fetch, 32'd10);
    check32("perf stall 20", perf_stall, 32'd20);
`endif

    // Randomized traffic against the reference model and a variable-latency I-cache.
    do_reset();
    begin
      bit          pend;
      logic [31:0] pend_addr;
      int          due;
      bit          branch, block, exp_req;
      int          pick;
      pend = 1'b0; pend_addr = 32'd0; due = 0;
      m_pc = 32'h8000_0000; m_ipc = 32'd0; m_inst = NOP;
      m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_fetch = 0; m_stall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        pick = $urandom_range(0, 99);
        ctrl   = (pick < 8) ? CTRL_BRANCH : (pick < 23) ? CTRL_BLOCK :
                 (pick < 28) ? CTRL_BUBBLE : CTRL_DEFAULT;
        ready  = ($urandom_range(0, 3) != 0);
        target = $urandom;
        dvalid = pend && (due == cyc);
        data   = dvalid ? mem_word(pend_addr) : $urandom;
        #1;
        branch  = (ctrl == CTRL_BRANCH);
        block   = (ctrl == CTRL_BLOCK) || (ctrl == CTRL_BUBBLE);
        exp_req = !m_hold && !m_busy && !block;
        check1($sformatf("rnd%0d req", cyc), req, exp_req);
        check32($sformatf("rnd%0d addr", cyc), addr, m_pc);
        check1($sformatf("rnd%0d valid", cyc), vld, m_hold);
        check32($sformatf("rnd%0d inst", cyc), inst, m_hold ? m_inst : NOP);
        if (m_hold) begin
          check32($sformatf("rnd%0d if_pc", cyc), ipc, m_ipc);
        end
        if (dvalid) pend = 1'b0;
        if (req && ready) begin
          pend = 1'b1; pend_addr = addr; due = cyc + int'($urandom_range(1, 4));
        end
        if (m_busy) m_stall++;
        if (m_hold) begin
          if (branch) begin
            m_pc = target; m_hold = 1'b0;
          end else if (!block) begin
            m_pc = m_pc + 32'd4; m_hold = 1'b0; m_fetch++;
          end
        end else if (m_busy) begin
          if (dvalid) begin
            if (!m_stale && !branch) begin
              m_hold = 1'b1; m_ipc = m_pc; m_inst = data;
            end
            m_busy = 1'b0; m_stale = 1'b0;
          end else if (branch) begin
            m_stale = 1'b1;
          end
          if (branch) m_pc = target;
        end else begin
          if (exp_req && ready) begin
            m_busy = 1'b1; m_stale = branch;
          end
          if (branch) m_pc = target;
        end
      end
`ifdef FETCH_PERF_CNT_EN
      @(negedge clk);
      #1;
      check32("rnd perf fetch", perf_fetch, 32'(m_fetch));
      check32("rnd perf stall", perf_stall, 32'(m_stall));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
